// File: rtl/rig_profile_pkg.sv
// Shared definitions for the instruction-stream profiler.
//   - RV32 opcode constants
//   - instruction class enum (its values are also the class counter indices)
//   - hazard counter indices
//   - decoded-word struct produced by rig_instr_classifier
package rig_profile_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        CLS_SHIFT     = 4'd0,
        CLS_OPERATION = 4'd1,
        CLS_COMPARE   = 4'd2,
        CLS_LOAD      = 4'd3,
        CLS_STORE     = 4'd4,
        CLS_DIV       = 4'd5,
        CLS_BR_LOOP   = 4'd6,
        CLS_BR_FWD    = 4'd7,
        CLS_OTHER     = 4'd8
    } instr_class_e;

    localparam logic [3:0] IDX_RAW = 4'd9;
    localparam logic [3:0] IDX_WAR = 4'd10;
    localparam logic [3:0] IDX_WAW = 4'd11;
    localparam int         NUM_CNT = 12;

    typedef struct packed {
        instr_class_e cls;
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic         rd_we;
        logic         rs1_re;
        logic         rs2_re;
    } decoded_t;

endpackage

// File: rtl/rig_instr_classifier.sv
// Combinational decode of one RV32IM word into its instruction class and
// the register fields it actually writes/reads.
//   instr : 32-bit instruction word
//   dec   : class, rd/rs1/rs2 and their write/read enables
module rig_instr_classifier
    import rig_profile_pkg::*;
(
    input  logic [31:0] instr,
    output decoded_t    dec
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_m;

    assign opc  = instr[6:0];
    assign f3   = instr[14:12];
    assign f7   = instr[31:25];
    // M-extension only exists in the register-register space; on OP-IMM
    // the f7 bits are immediate and must not be mistaken for MUL/DIV.
    assign is_m = (opc == OPC_OP) && (f7 == 7'b0000001);

    always_comb begin
        dec        = '0;
        dec.cls    = CLS_OTHER;
        dec.rd     = instr[11:7];
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        case (opc)
            OPC_OP, OPC_OP_IMM: begin
                dec.rd_we  = 1'b1;
                dec.rs1_re = 1'b1;
                dec.rs2_re = (opc == OPC_OP);
                if (is_m)
                    dec.cls = f3[2] ? CLS_DIV : CLS_OPERATION;
                else if (f3 == 3'b001 || f3 == 3'b101)
                    dec.cls = CLS_SHIFT;
                else if (f3 == 3'b010 || f3 == 3'b011)
                    dec.cls = CLS_COMPARE;
                else
                    dec.cls = CLS_OPERATION;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.rd_we = 1'b1;
                dec.cls   = CLS_OPERATION;
            end
            OPC_LOAD: begin
                dec.rd_we  = 1'b1;
                dec.rs1_re = 1'b1;
                dec.cls    = CLS_LOAD;
            end
            OPC_STORE: begin
                dec.rs1_re = 1'b1;
                dec.rs2_re = 1'b1;
                dec.cls    = CLS_STORE;
            end
            OPC_BRANCH: begin
                dec.rs1_re = 1'b1;
                dec.rs2_re = 1'b1;
                dec.cls    = instr[31] ? CLS_BR_LOOP : CLS_BR_FWD;
            end
            OPC_JAL: begin
                dec.rd_we = 1'b1;
            end
            OPC_JALR: begin
                dec.rd_we  = 1'b1;
                dec.rs1_re = 1'b1;
            end
            default: begin
                dec.cls = CLS_OTHER;
            end
        endcase
    end

endmodule

// File: rtl/rig_stream_profiler.sv
// Instruction-stream profiler: counts instruction classes and RAW/WAR/WAW
// hazards (against the previous accepted word) over a fixed-length window.
//   clk, rst   : clock, async active-high reset
//   start_i    : clear counters and open a window (IDLE/DONE only)
//   valid_i    : instruction word valid; instr_i : the word
//   ready_o    : word accepted this cycle when valid_i is high
//   busy_o     : window open; done_o : window complete, counters frozen
//   rd_sel_i   : counter index (classes 0..8, RAW 9, WAR 10, WAW 11)
//   rd_cnt_o   : selected counter, 0 for indices above 11
//   total_o    : accepted words in current/last window (saturating)
//
// state | meaning
// IDLE  | waiting for start_i
// COUNT | window open, accepting words
// DONE  | window complete, counters held until next start_i
module rig_stream_profiler
    import rig_profile_pkg::*;
#(
    parameter int NUM_INSTR = 500,
    parameter int CNT_W     = 16,
    parameter int XLEN      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             valid_i,
    input  logic [XLEN-1:0]  instr_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    input  logic [3:0]       rd_sel_i,
    output logic [CNT_W-1:0] rd_cnt_o,
    output logic [CNT_W-1:0] total_o
);

    // Window length is tracked at full width so a narrow CNT_W that
    // saturates total_o cannot stall the window.
    localparam int ACC_W = (NUM_INSTR < 2) ? 1 : $clog2(NUM_INSTR + 1);
    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(NUM_INSTR - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q;
    logic [CNT_W-1:0] cnt_q [NUM_CNT];
    logic [CNT_W-1:0] total_q;
    logic [ACC_W-1:0] acc_q;

    logic             prev_valid_q;
    logic [4:0]       prev_rd_q, prev_rs1_q, prev_rs2_q;
    logic             prev_rd_we_q, prev_rs1_re_q, prev_rs2_re_q;

    decoded_t         cur;
    logic             accept;
    logic             raw_hit, war_hit, waw_hit;
    logic [NUM_CNT-1:0] inc;

    rig_instr_classifier u_classifier (
        .instr (instr_i[31:0]),
        .dec   (cur)
    );

    assign accept = valid_i && (state_q == ST_COUNT);

    assign raw_hit = prev_valid_q && prev_rd_we_q && (prev_rd_q != 5'd0) &&
                     ((cur.rs1_re && cur.rs1 == prev_rd_q) ||
                      (cur.rs2_re && cur.rs2 == prev_rd_q));
    assign war_hit = prev_valid_q && cur.rd_we && (cur.rd != 5'd0) &&
                     ((prev_rs1_re_q && prev_rs1_q == cur.rd) ||
                      (prev_rs2_re_q && prev_rs2_q == cur.rd));
    assign waw_hit = prev_valid_q && cur.rd_we && prev_rd_we_q &&
                     (cur.rd != 5'd0) && (cur.rd == prev_rd_q);

    always_comb begin
        inc          = '0;
        inc[cur.cls] = 1'b1;
        inc[IDX_RAW] = raw_hit;
        inc[IDX_WAR] = war_hit;
        inc[IDX_WAW] = waw_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            total_q       <= '0;
            acc_q         <= '0;
            prev_valid_q  <= 1'b0;
            prev_rd_q     <= '0;
            prev_rs1_q    <= '0;
            prev_rs2_q    <= '0;
            prev_rd_we_q  <= 1'b0;
            prev_rs1_re_q <= 1'b0;
            prev_rs2_re_q <= 1'b0;
            for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
        end else if (state_q != ST_COUNT) begin
            if (start_i) begin
                state_q      <= ST_COUNT;
                total_q      <= '0;
                acc_q        <= '0;
                prev_valid_q <= 1'b0;
                for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < NUM_CNT; i++)
                if (inc[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
            if (total_q != '1) total_q <= total_q + 1'b1;
            acc_q         <= acc_q + 1'b1;
            prev_valid_q  <= 1'b1;
            prev_rd_q     <= cur.rd;
            prev_rs1_q    <= cur.rs1;
            prev_rs2_q    <= cur.rs2;
            prev_rd_we_q  <= cur.rd_we;
            prev_rs1_re_q <= cur.rs1_re;
            prev_rs2_re_q <= cur.rs2_re;
            if (acc_q == ACC_LAST) state_q <= ST_DONE;
        end
    end

    always_comb begin
        rd_cnt_o = '0;
        for (int i = 0; i < NUM_CNT; i++)
            if (rd_sel_i == 4'(i)) rd_cnt_o = cnt_q[i];
    end

    assign ready_o = (state_q == ST_COUNT);
    assign busy_o  = (state_q == ST_COUNT);
    assign done_o  = (state_q == ST_DONE);
    assign total_o = total_q;

endmodule

// File: tb/tb_rig_stream_profiler.sv
module tb_rig_stream_profiler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] instr = '0;
    logic [3:0]  rd_sel = '0;

    logic        ready3, busy3, done3;
    logic [15:0] cnt3, tot3;
    logic        ready4, busy4, done4;
    logic [15:0] cnt4, tot4;
    logic        ready5, busy5, done5;
    logic [1:0]  cnt5, tot5;

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [31:0] W_SLLI = 32'h00309093;
    localparam logic [31:0] W_ADD  = 32'h002081B3;
    localparam logic [31:0] W_DIV  = 32'h027342B3;
    localparam logic [31:0] W_SLT  = 32'h0020A233;
    localparam logic [31:0] W_LW   = 32'h0000A303;
    localparam logic [31:0] W_BEQ  = 32'hFE000EE3;
    localparam logic [31:0] W_NOP  = 32'h00000013;

    always #5 clk = ~clk;

    rig_stream_profiler #(.NUM_INSTR(3), .CNT_W(16), .XLEN(32)) u3 (
        .clk(clk), .rst(rst), .start_i(start), .valid_i(valid), .instr_i(instr),
        .ready_o(ready3), .busy_o(busy3), .done_o(done3), .rd_sel_i(rd_sel),
        .rd_cnt_o(cnt3), .total_o(tot3));
    rig_stream_profiler #(.NUM_INSTR(4), .CNT_W(16), .XLEN(32)) u4 (
        .clk(clk), .rst(rst), .start_i(start), .valid_i(valid), .instr_i(instr),
        .ready_o(ready4), .busy_o(busy4), .done_o(done4), .rd_sel_i(rd_sel),
        .rd_cnt_o(cnt4), .total_o(tot4));
    rig_stream_profiler #(.NUM_INSTR(5), .CNT_W(2), .XLEN(32)) u5 (
        .clk(clk), .rst(rst), .start_i(start), .valid_i(valid), .instr_i(instr),
        .ready_o(ready5), .busy_o(busy5), .done_o(done5), .rd_sel_i(rd_sel),
        .rd_cnt_o(cnt5), .total_o(tot5));

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        instr = w;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rd_sel = 4'd0; #1;
        total_cnt++; if (ready3 !== 1'b0) $display("FAIL reset_ready got %b exp 0", ready3); else pass_cnt++;
        total_cnt++; if (busy3 !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy3); else pass_cnt++;
        total_cnt++; if (done3 !== 1'b0) $display("FAIL reset_done got %b exp 0", done3); else pass_cnt++;
        total_cnt++; if (tot3 !== 16'd0) $display("FAIL reset_total got %0d exp 0", tot3); else pass_cnt++;
        total_cnt++; if (cnt3 !== 16'd0) $display("FAIL reset_cnt got %0d exp 0", cnt3); else pass_cnt++;
    endtask

    task automatic test_shift_add();
        do_reset();
        pulse_start();
        total_cnt++; if (busy3 !== 1'b1 || ready3 !== 1'b1) $display("FAIL t1_open busy %b ready %b exp 1 1", busy3, ready3); else pass_cnt++;
        send(W_SLLI);
        send(W_ADD);
        total_cnt++; if (done3 !== 1'b0) $display("FAIL t1_done_early got %b exp 0", done3); else pass_cnt++;
        send(W_ADD);
        total_cnt++; if (done3 !== 1'b1) $display("FAIL t1_done got %b exp 1", done3); else pass_cnt++;
        total_cnt++; if (ready3 !== 1'b0 || busy3 !== 1'b0) $display("FAIL t1_closed ready %b busy %b exp 0 0", ready3, busy3); else pass_cnt++;
        total_cnt++; if (tot3 !== 16'd3) $display("FAIL t1_total got %0d exp 3", tot3); else pass_cnt++;
        send(W_ADD);
        total_cnt++; if (tot3 !== 16'd3) $display("FAIL t1_no_accept_done got %0d exp 3", tot3); else pass_cnt++;
        rd_sel = 4'd0;  #1; total_cnt++; if (cnt3 !== 16'd1) $display("FAIL t1_shift got %0d exp 1", cnt3); else pass_cnt++;
        rd_sel = 4'd1;  #1; total_cnt++; if (cnt3 !== 16'd2) $display("FAIL t1_operation got %0d exp 2", cnt3); else pass_cnt++;
        rd_sel = 4'd9;  #1; total_cnt++; if (cnt3 !== 16'd1) $display("FAIL t1_raw got %0d exp 1", cnt3); else pass_cnt++;
        rd_sel = 4'd10; #1; total_cnt++; if (cnt3 !== 16'd0) $display("FAIL t1_war got %0d exp 0", cnt3); else pass_cnt++;
        rd_sel = 4'd11; #1; total_cnt++; if (cnt3 !== 16'd1) $display("FAIL t1_waw got %0d exp 1", cnt3); else pass_cnt++;
        rd_sel = 4'd12; #1; total_cnt++; if (cnt3 !== 16'd0) $display("FAIL t1_sel12 got %0d exp 0", cnt3); else pass_cnt++;
        rd_sel = 4'd15; #1; total_cnt++; if (cnt3 !== 16'd0) $display("FAIL t1_sel15 got %0d exp 0", cnt3); else pass_cnt++;
    endtask

    task automatic test_classes();
        logic [15:0] exp_cnt [12];
        exp_cnt = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd0, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        do_reset();
        pulse_start();
        send(W_DIV);
        send(W_SLT);
        send(W_LW);
        send(W_BEQ);
        total_cnt++; if (done4 !== 1'b1) $display("FAIL t2_done got %b exp 1", done4); else pass_cnt++;
        for (int i = 0; i < 12; i++) begin
            rd_sel = 4'(i); #1;
            total_cnt++;
            if (cnt4 !== exp_cnt[i]) $display("FAIL t2_cnt%0d got %0d exp %0d", i, cnt4, exp_cnt[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_valid_toggle();
        do_reset();
        pulse_start();
        instr = W_NOP;
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1;
            @(negedge clk);
            total_cnt++; if (tot4 !== 16'(i + 1)) $display("FAIL t3_beat%0d got %0d exp %0d", i, tot4, i + 1); else pass_cnt++;
            total_cnt++; if (done4 !== (i == 3)) $display("FAIL t3_done%0d got %b exp %b", i, done4, (i == 3)); else pass_cnt++;
            valid = 1'b0;
            @(negedge clk);
            total_cnt++; if (tot4 !== 16'(i + 1)) $display("FAIL t3_gap%0d got %0d exp %0d", i, tot4, i + 1); else pass_cnt++;
        end
        rd_sel = 4'd1; #1;
        total_cnt++; if (cnt4 !== 16'd4) $display("FAIL t3_operation got %0d exp 4", cnt4); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_reset();
        pulse_start();
        send(W_SLLI);
        send(W_SLLI);
        total_cnt++; if (tot3 !== 16'd2) $display("FAIL t4_pre got %0d exp 2", tot3); else pass_cnt++;
        #2 rst = 1'b1;
        rd_sel = 4'd0; #1;
        total_cnt++; if (tot3 !== 16'd0) $display("FAIL t4_total got %0d exp 0", tot3); else pass_cnt++;
        total_cnt++; if (busy3 !== 1'b0 || ready3 !== 1'b0) $display("FAIL t4_idle busy %b ready %b exp 0 0", busy3, ready3); else pass_cnt++;
        total_cnt++; if (cnt3 !== 16'd0) $display("FAIL t4_shift got %0d exp 0", cnt3); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        valid = 1'b1; instr = W_SLLI;
        @(negedge clk);
        @(negedge clk);
        valid = 1'b0;
        total_cnt++; if (ready3 !== 1'b0 || tot3 !== 16'd0) $display("FAIL t4_stay_idle ready %b total %0d exp 0 0", ready3, tot3); else pass_cnt++;
    endtask

    task automatic test_restart();
        do_reset();
        pulse_start();
        send(W_NOP);
        send(W_NOP);
        pulse_start();
        total_cnt++; if (tot4 !== 16'd2 || busy4 !== 1'b1) $display("FAIL t5_start_in_count total %0d busy %b exp 2 1", tot4, busy4); else pass_cnt++;
        send(W_NOP);
        send(W_NOP);
        total_cnt++; if (done4 !== 1'b1) $display("FAIL t5_done got %b exp 1", done4); else pass_cnt++;
        pulse_start();
        rd_sel = 4'd1; #1;
        total_cnt++; if (tot4 !== 16'd0) $display("FAIL t5_total_clr got %0d exp 0", tot4); else pass_cnt++;
        total_cnt++; if (busy4 !== 1'b1 || done4 !== 1'b0) $display("FAIL t5_reopen busy %b done %b exp 1 0", busy4, done4); else pass_cnt++;
        total_cnt++; if (cnt4 !== 16'd0) $display("FAIL t5_cnt_clr got %0d exp 0", cnt4); else pass_cnt++;
    endtask

    task automatic test_saturate();
        do_reset();
        pulse_start();
        for (int i = 0; i < 4; i++) send(W_SLLI);
        total_cnt++; if (done5 !== 1'b0) $display("FAIL t6_done_early got %b exp 0", done5); else pass_cnt++;
        send(W_SLLI);
        total_cnt++; if (done5 !== 1'b1) $display("FAIL t6_done got %b exp 1", done5); else pass_cnt++;
        total_cnt++; if (tot5 !== 2'd3) $display("FAIL t6_total got %0d exp 3", tot5); else pass_cnt++;
        rd_sel = 4'd0; #1;
        total_cnt++; if (cnt5 !== 2'd3) $display("FAIL t6_shift got %0d exp 3", cnt5); else pass_cnt++;
        rd_sel = 4'd9; #1;
        total_cnt++; if (cnt5 !== 2'd3) $display("FAIL t6_raw got %0d exp 3", cnt5); else pass_cnt++;
        rd_sel = 4'd1; #1;
        total_cnt++; if (cnt5 !== 2'd0) $display("FAIL t6_operation got %0d exp 0", cnt5); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_shift_add();
        test_classes();
        test_valid_toggle();
        test_async_reset();
        test_restart();
        test_saturate();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
